// File: rtl/serial_word_pkg.sv
// Shared types and helpers for the word-level serial adder front end.
package serial_word_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width: enough to count 0 .. width-1, never narrower than one bit.
  function automatic int COUNTER_W(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_word_adder_driver.sv
// Word-level driver for an external 1-bit serial adder: loads two operands,
// streams them LSB-first onto ser_a/ser_b, gathers ser_sum into res, and
// holds the result on a valid/ready output handshake.
module serial_word_adder_driver
  import serial_word_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_clear,
  input  logic             ser_sum,
  output logic [WIDTH-1:0] res,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int            CW       = COUNTER_W(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             load;

  // State register; reset aborts any word in flight and returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: DONE can reload directly into SHIFT for back-to-back words.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = in_valid ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; ser_clear stays high outside SHIFT so every word starts with carry 0.
  always_comb begin
    in_ready  = 1'b0;
    ser_clear = 1'b1;
    ser_a     = 1'b0;
    ser_b     = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      SHIFT: begin
        ser_clear = 1'b0;
        ser_a     = a_sh[0];
        ser_b     = b_sh[0];
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        load      = out_ready & in_valid;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath: load operands on handshake, then shift one bit per SHIFT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
    end else if (load) begin
      cnt  <= '0;
      a_sh <= a_in;
      b_sh <= b_in;
    end else if (state == SHIFT) begin
      res_sh <= {ser_sum, res_sh[WIDTH-1:1]};
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign res = res_sh;

endmodule

// File: tb/tb_serial_word_adder_driver.sv
// Directed bench for serial_word_adder_driver with a behavioural 1-bit serial
// adder (sync carry clear) wired between ser_a/ser_b/ser_clear and ser_sum.
module tb_serial_word_adder_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ser_a;
  logic       ser_b;
  logic       ser_clear;
  logic       ser_sum;
  logic [7:0] res;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       carry = 1'b0;

  int errors = 0;
  int checks = 0;

  serial_word_adder_driver #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_clear (ser_clear),
    .ser_sum   (ser_sum),
    .res       (res),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Serial adder model: full-adder sum, carry register with synchronous clear.
  assign ser_sum = ser_a ^ ser_b ^ carry;
  always @(posedge clk) begin
    if (ser_clear) carry <= 1'b0;
    else           carry <= (ser_a & ser_b) | (ser_a & carry) | (ser_b & carry);
  end

  // Runs one word from IDLE with out_ready high; returns the result seen on out_valid.
  task automatic run_word(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output bit seen);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    r = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        r = res;
      end
    end
    if (seen) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (ser_clear !== 1'b1) begin errors++; $display("[TB] FAIL reset_ser_clear: got %b expected 1", ser_clear); end
    checks++; if (res !== 8'h00) begin errors++; $display("[TB] FAIL reset_res: got %h expected 00", res); end
    checks++; if (ser_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_ser_a: got %b expected 0", ser_a); end
    checks++; if (ser_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_ser_b: got %b expected 0", ser_b); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // 0x3C + 0x05: bit-level stream check and handshake-to-out_valid latency.
  task automatic test_basic;
    logic [7:0] pa;
    logic [7:0] pb;
    pa = 8'h3C;
    pb = 8'h05;
    a_in = pa;
    b_in = pb;
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready_idle: got %b expected 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (ser_a !== pa[i]) begin errors++; $display("[TB] FAIL basic_ser_a bit %0d: got %b expected %b", i, ser_a, pa[i]); end
      checks++; if (ser_b !== pb[i]) begin errors++; $display("[TB] FAIL basic_ser_b bit %0d: got %b expected %b", i, ser_b, pb[i]); end
      checks++; if (ser_clear !== 1'b0) begin errors++; $display("[TB] FAIL basic_ser_clear_shift %0d: got %b expected 0", i, ser_clear); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid %0d: got %b expected 0", i, out_valid); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency: out_valid got %b expected 1", out_valid); end
    checks++; if (res !== 8'h41) begin errors++; $display("[TB] FAIL basic_res: got %h expected 41", res); end
    checks++; if (ser_clear !== 1'b1) begin errors++; $display("[TB] FAIL basic_ser_clear_done: got %b expected 1", ser_clear); end
    checks++; if (ser_a !== 1'b0) begin errors++; $display("[TB] FAIL basic_ser_a_done: got %b expected 0", ser_a); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_drop: got %b expected 0", out_valid); end
  endtask

  // 0xFF + 0x01 overflows; the next word 0x00 + 0x00 must not inherit the carry.
  task automatic test_carry_clear;
    logic [7:0] r;
    bit seen;
    run_word(8'hFF, 8'h01, r, seen);
    checks++; if (!seen || r !== 8'h00) begin errors++; $display("[TB] FAIL carry_wrap: got %h seen=%0d expected 00", r, seen); end
    run_word(8'h00, 8'h00, r, seen);
    checks++; if (!seen || r !== 8'h00) begin errors++; $display("[TB] FAIL carry_cleared: got %h seen=%0d expected 00", r, seen); end
  endtask

  // Result held with out_ready low for 5 cycles, released when out_ready rises.
  task automatic test_hold;
    bit seen;
    out_ready = 1'b0;
    a_in = 8'h12;
    b_in = 8'h34;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL hold_timeout: out_valid got 0 expected 1"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid %0d: got %b expected 1", i, out_valid); end
      checks++; if (res !== 8'h46) begin errors++; $display("[TB] FAIL hold_res %0d: got %h expected 46", i, res); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready %0d: got %b expected 0", i, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_in_ready_follow: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: out_valid got %b expected 0", out_valid); end
  endtask

  // Three words with in_valid held: results on out_valid pulses 9 cycles apart.
  task automatic test_back_to_back;
    logic [7:0] opa [3];
    logic [7:0] opb [3];
    logic [7:0] exp_r [3];
    int nseen;
    int cyc;
    int last;
    opa = '{8'h01, 8'h80, 8'h7F};
    opb = '{8'h02, 8'h80, 8'h01};
    exp_r = '{8'h03, 8'h00, 8'h80};
    nseen = 0;
    cyc = 0;
    last = 0;
    a_in = opa[0];
    b_in = opb[0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in = opa[1];
    b_in = opb[1];
    while (nseen < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        checks++; if (res !== exp_r[nseen]) begin errors++; $display("[TB] FAIL b2b_res word %0d: got %h expected %h", nseen, res, exp_r[nseen]); end
        if (nseen > 0) begin
          checks++; if (cyc - last !== 9) begin errors++; $display("[TB] FAIL b2b_spacing word %0d: got %0d expected 9", nseen, cyc - last); end
        end
        last = cyc;
        nseen++;
        @(posedge clk);
        #1;
        if (nseen == 1) begin
          a_in = opa[2];
          b_in = opb[2];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (nseen !== 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d words expected 3", nseen); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: out_valid got %b expected 0", out_valid); end
  endtask

  // Asynchronous reset in SHIFT cycle 4 of 0xAA + 0x55, then a clean 0x0F + 0x01.
  task automatic test_reset_mid_shift;
    logic [7:0] r;
    bit seen;
    a_in = 8'hAA;
    b_in = 8'h55;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (ser_clear !== 1'b0) begin errors++; $display("[TB] FAIL abort_in_shift: ser_clear got %b expected 0", ser_clear); end
    #1 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_out_valid: got %b expected 0", out_valid); end
    checks++; if (ser_clear !== 1'b1) begin errors++; $display("[TB] FAIL abort_ser_clear: got %b expected 1", ser_clear); end
    checks++; if (res !== 8'h00) begin errors++; $display("[TB] FAIL abort_res: got %h expected 00", res); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_word(8'h0F, 8'h01, r, seen);
    checks++; if (!seen || r !== 8'h10) begin errors++; $display("[TB] FAIL abort_next_word: got %h seen=%0d expected 10", r, seen); end
  endtask

  // New operands offered mid-SHIFT must be refused and leave the word intact.
  task automatic test_ignore_busy;
    bit seen;
    logic [7:0] r;
    a_in = 8'h21;
    b_in = 8'h43;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_in = 8'h7E;
    b_in = 8'h7E;
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    r = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        r = res;
      end
    end
    checks++; if (!seen || r !== 8'h64) begin errors++; $display("[TB] FAIL busy_res: got %h seen=%0d expected 64", r, seen); end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting serial_word_adder_driver bench");
    test_reset();
    test_basic();
    test_carry_clear();
    test_hold();
    test_back_to_back();
    test_reset_mid_shift();
    test_ignore_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_adder_driver.md
Name: serial_word_adder_driver

Overview:
- Word-level front end for the 1-bit serial adder.
- Accepts two WIDTH-bit operands over a valid/ready handshake and shifts them LSB-first onto the serial adder's `a`/`b` inputs.
- Drives the adder's synchronous carry-clear and collects the returned `sum` bits into a parallel result.
- Presents the result on a valid/ready output handshake. The serial adder itself stays a separate instance wired between `ser_*` ports.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  one clock; reset is asynchronous and active-low (rst = 0 resets)
a_in  input  WIDTH  operand A, sampled on input handshake
b_in  input  WIDTH  operand B, sampled on input handshake
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands this cycle
ser_a  output  1  current bit of A to serial adder input `a`
ser_b  output  1  current bit of B to serial adder input `b`
ser_clear  output  1  to serial adder's synchronous reset; forces its carry to 0
ser_sum  input  1  serial adder `sum` output (combinational from ser_a, ser_b, carry)
res  output  WIDTH  (A + B) mod 2^WIDTH
out_valid  output  1  res valid
out_ready  input  1  consumer accepts res

Behaviour:
- Reset values (async, rst low):
  - state = IDLE, bit counter = 0, operand and result shift registers = 0.
  - res = 0, out_valid = 0, ser_a = ser_b = 0, ser_clear = 1, in_ready = 1.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, ser_clear = 1.
  - On in_valid: load a_in/b_in into the shift registers, counter = 0, go to SHIFT.
- SHIFT: lasts exactly WIDTH cycles.
  - ser_clear = 0, in_ready = 0.
  - ser_a/ser_b = LSB of the A/B shift registers.
  - Each cycle at posedge:
    - sample ser_sum into the result register MSB, shifting right, so bit 0 ends at res[0];
    - shift A/B right;
    - counter += 1.
  - When counter == WIDTH-1 at the edge, go to DONE.
- DONE:
  - out_valid = 1, res stable, ser_clear = 1, ser_a = ser_b = 0.
  - in_ready = out_ready (combinational).
  - On out_ready && in_valid: load new operands and go directly to SHIFT (back-to-back).
  - On out_ready && !in_valid: go to IDLE.
  - On !out_ready: hold.
- Carry rule:
  - ser_clear is high in every cycle outside SHIFT, so the adder carry is 0 in the first SHIFT cycle of every word.
  - Carry out of the MSB is discarded (modulo result).
- Latency: input handshake at edge k → SHIFT cycles k+1 .. k+WIDTH → out_valid = 1 from cycle k+WIDTH+1.
- Throughput: one word per WIDTH+1 cycles with out_ready held high and in_valid continuous.
- ser_a/ser_b are 0 in IDLE and DONE; ser_sum is ignored outside SHIFT.
- in_valid while in_ready = 0: no effect; the upstream must hold its data.
- out_valid, once high, stays high with res unchanged until out_ready. No combinational path from in_valid to out_valid.
- Reset mid-SHIFT or mid-DONE: word aborted, no out_valid, ser_clear high immediately (asynchronous).
- Counter width is $clog2(WIDTH); no wrap beyond WIDTH-1.

Decomposition:
- Package `serial_word_pkg`: state enum typedef (IDLE, SHIFT, DONE) and a COUNTER_W helper function.
- No sub-module; the block is flat.
- The bench instantiates the existing serial adder between ser_a/ser_b/ser_clear and ser_sum.

Test Plan:
- WIDTH=8, a_in=0x3C, b_in=0x05, out_ready=1 → out_valid asserted 9 cycles after the handshake edge; res = 0x41; ser_a sequence LSB-first 0,0,1,1,1,1,0,0.
- a_in=0xFF, b_in=0x01, then a_in=0x00, b_in=0x00 → res = 0x00, then res = 0x00 (carry correctly cleared between words, not 0x01).
- a_in=0x12, b_in=0x34 with out_ready low for 5 cycles after out_valid → res = 0x46 held stable, in_ready = 0 throughout; out_valid drops the cycle after out_ready = 1.
- Back-to-back: in_valid held, out_ready=1, words (0x01+0x02), (0x80+0x80), (0x7F+0x01) → res = 0x03, 0x00, 0x80 on consecutive out_valid pulses spaced 9 cycles apart.
- rst driven low during SHIFT cycle 4 of 0xAA+0x55 → immediately state IDLE, out_valid = 0, ser_clear = 1, res = 0; a following 0x0F+0x01 yields 0x10.
- in_valid pulsed during SHIFT with different data → ignored; the original result is produced unchanged.
